// File: rtl/fp_min_reduce_seq.sv
// Burst minimum reducer: folds N floating-point elements through a two-operand
// min against a running accumulator and returns the result with a sticky sNaN flag.
module fp_min_reduce_seq #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [CNT_W-1:0]                  cmd_len,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0]   in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0]   out_data,
    output logic [4:0]                        out_status
);

    localparam int W = SIGN_W + EXPO_W + MANT_W;

    typedef enum logic [1:0] {IDLE, FIRST, ACC, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   rem;
    logic [W-1:0]       acc;
    logic               invalid;

    logic cmd_fire;
    logic in_fire;
    logic out_fire;

    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[MANT_W +: EXPO_W]) && (|x[MANT_W-1:0]);
    endfunction

    function automatic logic is_snan(input logic [W-1:0] x);
        return is_nan(x) && !x[MANT_W-1];
    endfunction

    // Ordering is NaN-avoiding; ties and equal zeros fall back to operand a
    // so the first-seen value survives the reduction.
    function automatic logic [W-1:0] fp_min(input logic [W-1:0] a, input logic [W-1:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_neg, b_neg;
        logic [EXPO_W-1:0] ae, be;
        logic [MANT_W-1:0] am, bm;
        logic [W-1:0]      r;
        ae     = a[MANT_W +: EXPO_W];
        be     = b[MANT_W +: EXPO_W];
        am     = a[MANT_W-1:0];
        bm     = b[MANT_W-1:0];
        a_neg  = a[W-1];
        b_neg  = b[W-1];
        a_nan  = is_nan(a);
        b_nan  = is_nan(b);
        a_inf  = (&ae) && (am == '0);
        b_inf  = (&be) && (bm == '0);
        a_zero = (ae == '0) && (am == '0);
        b_zero = (be == '0) && (bm == '0);
        r      = b;
        if (a_nan) begin
            r = b_nan ? a : b;
        end else if (b_nan) begin
            r = a;
        end else if (a_inf) begin
            r = a_neg ? a : b;
        end else if (b_inf) begin
            r = b_neg ? b : a;
        end else if (a_zero && b_zero) begin
            r = a;
        end else if (a_neg != b_neg) begin
            r = a_neg ? a : b;
        end else if (!a_neg) begin
            if (ae < be)      r = a;
            else if (ae > be) r = b;
            else              r = (am < bm) ? a : b;
        end else begin
            if (ae > be)      r = a;
            else if (ae < be) r = b;
            else              r = (am < bm) ? b : a;
        end
        return r;
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign in_ready   = (state == FIRST) || (state == ACC);
    assign out_valid  = (state == DONE);
    assign out_data   = acc;
    assign out_status = {4'b0000, invalid};

    assign cmd_fire = cmd_valid && cmd_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cmd_fire) state_next = FIRST;
            FIRST: if (in_fire)  state_next = (rem == '0) ? DONE : ACC;
            ACC:   if (in_fire && rem == '0) state_next = DONE;
            DONE:  if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            acc     <= '0;
            invalid <= 1'b0;
        end else begin
            if (cmd_fire) begin
                rem     <= cmd_len;
                invalid <= 1'b0;
            end
            if (in_fire) begin
                acc     <= (state == FIRST) ? in_data : fp_min(acc, in_data);
                invalid <= invalid | is_snan(in_data);
                if (rem != '0) rem <= rem - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_min_reduce_seq.sv
// Randomized and directed bench for fp_min_reduce_seq, checked against a
// numeric-ordering reference model of the FP32 min reduction.
module tb_fp_min_reduce_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_status;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] burst[$];

    fp_min_reduce_seq #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_status(out_status)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit ref_is_snan(input logic [31:0] x);
        return ref_is_nan(x) && !x[22];
    endfunction

    // Sign-magnitude bits map to a signed integer that orders like the real values.
    function automatic longint ref_key(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] ref_min(input logic [31:0] a, input logic [31:0] b);
        if (ref_is_nan(a)) return ref_is_nan(b) ? a : b;
        if (ref_is_nan(b)) return a;
        if (a[30:0] == 0 && b[30:0] == 0) return a;
        return (ref_key(b) < ref_key(a)) ? b : a;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        case ($urandom_range(9))
            0: v = {1'($urandom), 31'h0};
            1: v = {1'($urandom), 8'hFF, 23'h0};
            2: v = {1'($urandom), 8'hFF, 1'b1, 22'($urandom)};
            3: v = {1'($urandom), 8'hFF, 1'b0, 21'($urandom), 1'b1};
            default: v = {1'($urandom), 8'(120 + $urandom_range(5)), 23'($urandom_range(7) << 20)};
        endcase
        return v;
    endfunction

    task automatic applyStimulus(input string tag, input int gap_pct, input int stall);
        logic [31:0] exp_data;
        logic        exp_inv;
        logic [31:0] held_d;
        logic [4:0]  held_s;
        int          idx, cycles, guard;
        bit          take;
        exp_data = burst[0];
        exp_inv  = 1'b0;
        foreach (burst[i]) begin
            exp_inv = exp_inv | ref_is_snan(burst[i]);
            if (i > 0) exp_data = ref_min(exp_data, burst[i]);
        end
        checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = 8'(burst.size() - 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_len   = 8'($urandom);
        cycles = 2;
        idx = 0;
        guard = 0;
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        while (idx < burst.size() && guard < 5000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? burst[idx] : $urandom;
            take     = in_valid && in_ready;
            @(posedge clk); #1;
            cycles++;
            guard++;
            if (take) idx++;
        end
        in_valid = 1'b0;
        checkOutput({tag, ".elems"}, 32'(idx), 32'(burst.size()));
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            cycles++;
            guard++;
        end
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        if (gap_pct == 0) checkOutput({tag, ".latency"}, 32'(cycles), 32'(burst.size() + 2));
        held_d = out_data;
        held_s = out_status;
        out_ready = 1'b0;
        cmd_valid = (stall > 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checkOutput({tag, ".hold_data"}, out_data, held_d);
            checkOutput({tag, ".hold_status"}, 32'(out_status), 32'(held_s));
            checkOutput({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        checkOutput({tag, ".data"}, out_data, exp_data);
        checkOutput({tag, ".status"}, 32'(out_status), {27'd0, 4'd0, exp_inv});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".out_data"}, out_data, 32'd0);
        checkOutput({tag, ".out_status"}, 32'(out_status), 32'd0);
    endtask

    initial begin
        #1;
        checkReset("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        burst = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'hBF800000};
        applyStimulus("basic", 0, 0);
        burst = '{32'h7FC00000, 32'h3F800000, 32'h7F800001};
        applyStimulus("nan_mix", 0, 0);
        burst = '{32'h00000000, 32'h80000000};
        applyStimulus("zero_pos_first", 0, 0);
        burst = '{32'h80000000, 32'h00000000};
        applyStimulus("zero_neg_first", 0, 0);
        burst = '{32'h7F800001};
        applyStimulus("single_snan", 0, 0);
        burst = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
        applyStimulus("infs", 0, 0);

        burst.delete();
        for (int i = 0; i < 9; i++) burst.push_back(rand_fp());
        applyStimulus("stall", 40, 5);

        // Abandon a burst part way through with an asynchronous reset.
        cmd_valid = 1'b1;
        cmd_len   = 8'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC1000000;
        @(posedge clk); #1;
        in_data   = 32'h3F000000;
        @(posedge clk); #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checkReset("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        burst = '{32'h40000000, 32'h3F800000};
        applyStimulus("after_reset", 0, 0);

        for (int t = 0; t < 20; t++) begin
            burst.delete();
            for (int i = 0, n = $urandom_range(1, 16); i < n; i++) burst.push_back(rand_fp());
            applyStimulus($sformatf("rand%0d", t), $urandom_range(0, 1) * 30, $urandom_range(0, 3));
        end

        burst.delete();
        for (int i = 0; i < 256; i++) burst.push_back(rand_fp());
        applyStimulus("max_len", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
